// File: rtl/obf_seq_pkg.sv
// rtl/obf_seq_pkg.sv - shared widths and state encoding for the obfuscation sequencer
package obf_seq_pkg;

  localparam int OBF_PPC_WIDTH  = 4;
  localparam int OBF_KEY_WIDTH  = 8;
  localparam int OBF_INSN_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2
  } obf_state_e;

endpackage

// File: rtl/obf_seq.sv
// rtl/obf_seq.sv - expands each fetched word into a generator-driven substitution sequence
// or passes it through, one output word per handshake toward decode.
module obf_seq
  import obf_seq_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      obf_en,
  input  logic [OBF_KEY_WIDTH-1:0]  obf_key_i,
  input  logic                      in_valid,
  input  logic [OBF_INSN_WIDTH-1:0] in_insn,
  output logic                      in_ready,
  input  logic                      flush,
  output logic [OBF_INSN_WIDTH-1:0] gen_ref_insn,
  output logic [OBF_PPC_WIDTH-1:0]  gen_ppc,
  output logic [OBF_KEY_WIDTH-1:0]  gen_key,
  input  logic [OBF_INSN_WIDTH-1:0] gen_insn,
  input  logic                      gen_last,
  input  logic                      gen_skip,
  output logic                      out_valid,
  output logic [OBF_INSN_WIDTH-1:0] out_insn,
  input  logic                      out_ready,
  output logic                      out_first,
  output logic                      err_ovf
);

  localparam logic [OBF_PPC_WIDTH:0] PPC_ONE = (OBF_PPC_WIDTH+1)'(1);

  obf_state_e                r_state, w_state_nxt;
  logic [OBF_PPC_WIDTH-1:0]  r_ppc, w_ppc_nxt;
  logic [OBF_INSN_WIDTH-1:0] r_insn, w_insn_nxt;
  logic [OBF_KEY_WIDTH-1:0]  r_key, w_key_nxt;
  logic                      r_ovf, w_ovf_nxt;

  logic [OBF_PPC_WIDTH:0] w_ppc_sum;
  logic                   w_wrap;
  logic                   w_hs;
  logic                   w_term;
  logic                   w_accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_ppc   <= '0;
      r_insn  <= '0;
      r_key   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ppc   <= w_ppc_nxt;
      r_insn  <= w_insn_nxt;
      r_key   <= w_key_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ppc_nxt   = r_ppc;
    w_insn_nxt  = r_insn;
    w_key_nxt   = r_key;
    w_ovf_nxt   = 1'b0;
    out_insn    = r_insn;
    out_first   = 1'b0;
    w_term      = 1'b0;

    // Carry out of the extended sum means the pointer would wrap.
    w_ppc_sum = {1'b0, r_ppc} + PPC_ONE + {{OBF_PPC_WIDTH{1'b0}}, gen_skip};
    w_wrap    = w_ppc_sum[OBF_PPC_WIDTH];

    case (r_state)
      ST_RUN: begin
        out_insn  = gen_insn;
        out_first = (r_ppc == '0);
        w_term    = gen_last | w_wrap;
      end
      ST_PASS: begin
        out_first = 1'b1;
        w_term    = 1'b1;
      end
      default: ;
    endcase

    out_valid = (r_state != ST_IDLE);
    w_hs      = out_valid & out_ready;
    in_ready  = !flush & ((r_state == ST_IDLE) | (w_hs & w_term));
    w_accept  = in_valid & in_ready;

    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_ppc_nxt   = '0;
    end else begin
      if (w_hs && w_term) begin
        w_state_nxt = ST_IDLE;
      end else if (w_hs && r_state == ST_RUN) begin
        w_ppc_nxt = w_ppc_sum[OBF_PPC_WIDTH-1:0];
      end
      if (w_hs && r_state == ST_RUN && !gen_last && w_wrap) begin
        w_ovf_nxt = 1'b1;
      end
      // A fresh word may be taken in the same cycle the current one terminates.
      if (w_accept) begin
        w_state_nxt = obf_en ? ST_RUN : ST_PASS;
        w_ppc_nxt   = '0;
        w_insn_nxt  = in_insn;
        w_key_nxt   = obf_key_i;
      end
    end
  end

  assign gen_ref_insn = r_insn;
  assign gen_ppc      = r_ppc;
  assign gen_key      = r_key;
  assign err_ovf      = r_ovf;

endmodule

// File: doc/obf_seq.md
OBF_SEQ -- requirements
Module: obf_seq

Interface
REQ-001 `OBF_PPC_WIDTH, 4, width of the substitution-sequence pointer (ppc) (from obf_defines.v).
REQ-002 `OBF_KEY_WIDTH, 8, width of the obfuscation key (from obf_defines.v).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 obf_en  in  1  1 = substitute; 0 = pass-through, one word per input.
REQ-006 obf_key_i  in  KEY  key from SPR; sampled only at input accept.
REQ-007 in_valid  in  1  fetch word valid.
REQ-008 in_insn  in  32  fetched reference instruction.
REQ-009 in_ready  out  1  block accepts in_insn this cycle.
REQ-010 flush  in  1  branch/exception flush, synchronous.
REQ-011 gen_ref_insn  out  32  held reference instruction to generator.
REQ-012 gen_ppc  out  PPC  current sequence pointer to generator.
REQ-013 gen_key  out  KEY  held key to generator.
REQ-014 gen_insn, gen_last, gen_skip  in  32/1/1  generator result for (gen_ref_insn, gen_ppc, gen_key).
REQ-015 out_valid  out  1  out_insn valid toward decode.
REQ-016 out_insn  out  32  emitted instruction.
REQ-017 out_ready  in  1  decode consumes out_insn (not frozen).
REQ-018 out_first  out  1  emitted word is first of its sequence (PC tracking).
REQ-019 err_ovf  out  1  one-cycle pulse: sequence forcibly terminated by ppc wrap.

Function
REQ-020 FSM states IDLE, RUN, PASS; reset state IDLE.
REQ-021 in_ready = IDLE, or (RUN/PASS and out_ready and current word terminating), and never while flush=1.
REQ-022 Accept (in_valid & in_ready): latch in_insn, obf_key_i; ppc<=0; next state RUN if obf_en=1 else PASS.
REQ-023 Latency: word accepted in cycle N produces out_valid=1 in cycle N+1.
REQ-024 out_valid = 1 in RUN and PASS, 0 in IDLE.
REQ-025 RUN: out_insn = gen_insn; PASS: out_insn = latched ref insn.
REQ-026 out_first = 1 when ppc==0 in RUN, always 1 in PASS.
REQ-027 RUN handshake (out_valid & out_ready): if gen_last=1 word terminates; else ppc <= ppc+1+gen_skip.
REQ-028 If ppc+1+gen_skip overflows PPC width (e.g. ppc=15, skip=0; ppc=14, skip=1) without gen_last: terminate, pulse err_ovf next cycle, ppc not wrapped.
REQ-029 PASS handshake always terminates.
REQ-030 On termination: next state from a simultaneous accept (REQ-022), else IDLE.
REQ-031 No handshake (out_ready=0): ppc, latched insn, key, out_insn stable.
REQ-032 obf_key_i/obf_en changes mid-sequence do not affect the running sequence.
REQ-033 flush=1: next cycle state IDLE, ppc 0, out_valid 0, no accept that cycle; flush wins over any handshake.

Reset
REQ-034 rst=0 asynchronously forces: state IDLE, ppc 0, latched insn 0, key 0, out_valid 0, err_ovf 0; in_ready=1 in first cycle after release.

Structure
REQ-035 State encodings and OBF_PPC_WIDTH/OBF_KEY_WIDTH in shared obf_defines.v; no local literals.
REQ-036 No sub-module; obf_insngen is instantiated beside it by integrator, wired via gen_* ports.

Verification
REQ-037 obf_en=0, in_insn=0xE0642000 accepted cycle 1 -> out_valid cycle 2, out_insn=0xE0642000, out_first=1, in_ready=1 same cycle with out_ready=1.
REQ-038 obf_en=1, model gen_last at ppc=2, out_ready=1 -> three words ppc 0,1,2, out_first only on ppc 0, in_ready high only in ppc-2 cycle.
REQ-039 gen_skip=1 at ppc=0 -> next gen_ppc=2; out_ready=0 for 3 cycles at ppc=2 -> outputs frozen.
REQ-040 gen_last never asserted, skip=0 -> after ppc=15 handshake: err_ovf=1 one cycle, state IDLE.
REQ-041 flush at ppc=1 with out_ready=1 and in_valid=1 -> next cycle out_valid=0, ppc 0, new insn not accepted.
REQ-042 rst=0 mid-RUN at ppc=3 -> immediately out_valid=0, gen_ppc=0; after release first accept restarts at ppc 0.
